// File: rtl/xtile_row_streamer_if.sv
`default_nettype none
// ============================================================================
// xtile_row_streamer_if : command, X SRAM read port and row-stream bundle.
// k_stride exists only when XSTREAM_STRIDE_EN is defined.  Revision: 1.0
// ============================================================================
interface xtile_row_streamer_if #(
  parameter int N      = 8,
  parameter int KMAX   = 1024,
  parameter int DATA_W = 32,
  parameter int K_W    = $clog2(KMAX),
  parameter int N_W    = $clog2(N)
);
  logic                start;
  logic [K_W-1:0]      k_base;
  logic [K_W:0]        k_count;
`ifdef XSTREAM_STRIDE_EN
  logic [K_W-1:0]      k_stride;
`endif
  logic                busy;
  logic                done;
  logic                rd_en;
  logic [K_W-1:0]      rd_k;
  logic [N_W-1:0]      rd_n;
  logic                rd_valid;
  logic [DATA_W-1:0]   rd_data;
  logic                row_valid;
  logic                row_ready;
  logic [K_W-1:0]      row_k;
  logic [N*DATA_W-1:0] row_data;
  logic                row_last;

  modport master (
    input  start, k_base, k_count,
`ifdef XSTREAM_STRIDE_EN
    input  k_stride,
`endif
    output busy, done, rd_en, rd_k, rd_n,
    input  rd_valid, rd_data,
    output row_valid, row_k, row_data, row_last,
    input  row_ready
  );

  modport slave (
    output start, k_base, k_count,
`ifdef XSTREAM_STRIDE_EN
    output k_stride,
`endif
    input  busy, done, rd_en, rd_k, rd_n,
    output rd_valid, rd_data,
    input  row_valid, row_k, row_data, row_last,
    output row_ready
  );
endinterface
`default_nettype wire

// File: rtl/xtile_row_streamer.sv
`default_nettype none
// ============================================================================
// xtile_row_streamer : streams k_count X rows from SRAM through two ping-pong
// row buffers. Optional macro XSTREAM_STRIDE_EN adds k_stride. Revision: 1.0
// ============================================================================
module xtile_row_streamer #(
  parameter int N      = 8,
  parameter int KMAX   = 1024,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1,
  parameter int K_W    = $clog2(KMAX),
  parameter int N_W    = $clog2(N)
) (
  input wire logic clk,
  input wire logic rst_n,
  xtile_row_streamer_if.master bus
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [N_W-1:0] C_N_LAST = N_W'(N - 1);
  localparam logic [K_W:0]   C_KMAX   = (K_W+1)'(KMAX);

  if (N < 2 || RD_LAT < 1 || RD_LAT > 4) begin : g_param_check
    $error("xtile_row_streamer: unsupported N or RD_LAT");
  end

  state_t              r_state;
  logic                r_busy, r_done, r_rd_en;
  logic [K_W-1:0]      r_rd_k;
  logic [N_W-1:0]      r_rd_n;
  logic [K_W-1:0]      r_nxt_k;
  logic [N_W-1:0]      r_nxt_n;
  logic                r_nxt_sel;
  logic [K_W:0]        r_nxt_left;
  logic [1:0]          r_alloc, r_full, r_buf_last;
  logic [K_W-1:0]      r_buf_k [2];
  logic [N*DATA_W-1:0] r_buf_data [2];
  logic                r_wr_sel, r_rd_sel;
  logic [N_W-1:0]      r_ret_n;
`ifdef XSTREAM_STRIDE_EN
  logic [K_W-1:0]      r_stride;
`endif

  logic           w_hs, w_launch, w_issue, w_sel;
  logic [1:0]     w_free;
  logic [K_W-1:0] w_k, w_k_nxt, w_stride;
  logic [N_W-1:0] w_n;
  logic [K_W:0]   w_left, w_k_sum;

  assign w_hs     = r_full[r_rd_sel] & bus.row_ready;
  assign w_launch = (r_state == S_IDLE) & bus.start & (bus.k_count != '0);

  // Issue pointer seen by this edge: the fresh command on launch, else the stored one.
  always_comb begin
    w_k    = r_nxt_k;
    w_n    = r_nxt_n;
    w_sel  = r_nxt_sel;
    w_left = r_nxt_left;
`ifdef XSTREAM_STRIDE_EN
    w_stride = w_launch ? bus.k_stride : r_stride;
`else
    w_stride = K_W'(1);
`endif
    if (w_launch) begin
      w_k    = bus.k_base;
      w_n    = '0;
      w_sel  = 1'b0;
      w_left = bus.k_count;
    end
    w_free = ~r_alloc;
    if (w_hs) w_free[r_rd_sel] = 1'b1;
  end

  assign w_issue = (w_launch | (r_state == S_RUN)) & (w_left != '0) &
                   ((w_n != '0) | w_free[w_sel]);
  assign w_k_sum = {1'b0, w_k} + {1'b0, w_stride};
  assign w_k_nxt = (w_k_sum >= C_KMAX) ? K_W'(w_k_sum - C_KMAX) : w_k_sum[K_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_en    <= 1'b0;
      r_rd_k     <= '0;
      r_rd_n     <= '0;
      r_nxt_k    <= '0;
      r_nxt_n    <= '0;
      r_nxt_sel  <= 1'b0;
      r_nxt_left <= '0;
      r_alloc    <= '0;
      r_full     <= '0;
      r_buf_last <= '0;
      r_buf_k[0] <= '0;
      r_buf_k[1] <= '0;
      r_wr_sel   <= 1'b0;
      r_rd_sel   <= 1'b0;
      r_ret_n    <= '0;
`ifdef XSTREAM_STRIDE_EN
      r_stride   <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.start) begin
          if (bus.k_count != '0) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_RUN: if (w_hs && r_buf_last[r_rd_sel]) begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (w_launch) begin
        r_wr_sel <= 1'b0;
        r_rd_sel <= 1'b0;
`ifdef XSTREAM_STRIDE_EN
        r_stride <= bus.k_stride;
`endif
      end

      // Returns always land in order, so wr_sel tracks issue order exactly.
      if (bus.rd_valid) begin
        if (r_ret_n == C_N_LAST) begin
          r_full[r_wr_sel] <= 1'b1;
          r_wr_sel         <= ~r_wr_sel;
          r_ret_n          <= '0;
        end else begin
          r_ret_n <= r_ret_n + N_W'(1);
        end
      end

      if (w_hs) begin
        r_full[r_rd_sel]  <= 1'b0;
        r_alloc[r_rd_sel] <= 1'b0;
        r_rd_sel          <= ~r_rd_sel;
      end

      // Allocation follows the handshake clear so a just-freed buffer can be reused.
      r_rd_en <= w_issue;
      if (w_issue) begin
        r_rd_k <= w_k;
        r_rd_n <= w_n;
        if (w_n == '0) begin
          r_alloc[w_sel]    <= 1'b1;
          r_buf_k[w_sel]    <= w_k;
          r_buf_last[w_sel] <= (w_left == (K_W+1)'(1));
        end
        if (w_n == C_N_LAST) begin
          r_nxt_n    <= '0;
          r_nxt_k    <= w_k_nxt;
          r_nxt_sel  <= ~w_sel;
          r_nxt_left <= w_left - (K_W+1)'(1);
        end else begin
          r_nxt_n    <= w_n + N_W'(1);
          r_nxt_k    <= w_k;
          r_nxt_sel  <= w_sel;
          r_nxt_left <= w_left;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bus.rd_valid) r_buf_data[r_wr_sel][int'(r_ret_n)*DATA_W +: DATA_W] <= bus.rd_data;
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.rd_en     = r_rd_en;
  assign bus.rd_k      = r_rd_k;
  assign bus.rd_n      = r_rd_n;
  assign bus.row_valid = r_full[r_rd_sel];
  assign bus.row_k     = r_full[r_rd_sel] ? r_buf_k[r_rd_sel] : '0;
  assign bus.row_last  = r_full[r_rd_sel] & r_buf_last[r_rd_sel];
  assign bus.row_data  = r_full[r_rd_sel] ? r_buf_data[r_rd_sel] : '0;
endmodule
`default_nettype wire

// File: doc/xtile_row_streamer.md
Name: xtile_row_streamer

Overview:
- Parametrised successor to the single-row X-tile loader.
- One start command streams a run of k_count X rows, starting at k_base, out of an external X SRAM read port with configurable read latency.
- Each row is packed into one of two ping-pong row buffers and presented as a full N-element row on a valid/ready output, so fetching row i+1 overlaps consumption of row i.
- Sits between the X SRAM and the systolic array row feeder.

Parameters:
- N, 8, elements per row (N>=2)
- KMAX, 1024, rows in X SRAM; row addresses wrap modulo KMAX
- DATA_W, 32, element width
- RD_LAT, 1, fixed SRAM read latency in cycles (1..4)
- K_W, $clog2(KMAX), row index width (derived)
- N_W, $clog2(N), element index width (derived)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  command pulse; accepted only in IDLE
- k_base  in  K_W  first row index; latched at start
- k_count  in  K_W+1  number of rows, 0..KMAX; latched at start
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at end of command
- rd_en  out  1  SRAM read request
- rd_k  out  K_W  SRAM row address
- rd_n  out  N_W  SRAM element address
- rd_valid  in  1  read return; asserted exactly RD_LAT cycles after rd_en, in order
- rd_data  in  DATA_W  read return data
- row_valid  out  1  full row available
- row_ready  in  1  consumer accepts row
- row_k  out  K_W  row index of the presented row
- row_data  out  N*DATA_W  presented row; element n at bits [n*DATA_W +: DATA_W]
- row_last  out  1  presented row is the final row of the command

Behaviour:
- Reset: all outputs 0; FSM IDLE; both buffers EMPTY; counters, wr_sel and rd_sel cleared.
- rd_valid is guaranteed low during and after reset until a new rd_en is issued (SRAM shares rst_n).
- FSM states:
  - IDLE: start=1 with k_count>0 latches inputs, goes to RUN, and busy=1 from the next cycle.
  - IDLE: start=1 with k_count=0 goes to DONE; no reads are issued.
  - RUN: issues reads and returns rows. Leaves RUN when all k_count rows have been handshaken.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- start is ignored while not in IDLE.
- Issue side:
  - One read per cycle. Issue row i, element n: rd_en=1, rd_k=(k_base+i) mod KMAX, rd_n=n.
  - n runs 0..N-1, then i increments.
  - Element 0 of row i is issued only if buffer (i mod 2) is EMPTY. Issue of that row's remaining elements then continues uninterrupted.
  - A buffer freed by a handshake at edge t may be issued into from cycle t+1.
- Return side:
  - rd_data is written to buf[wr_sel][n_ret], and n_ret increments.
  - At n_ret=N-1 the buffer becomes FULL, wr_sel toggles, and n_ret returns to 0.
- Output side:
  - row_valid=1 exactly when buf[rd_sel] is FULL; row_data, row_k and row_last are taken from that buffer.
  - Handshake (row_valid & row_ready) sets the buffer EMPTY and toggles rd_sel.
  - row_valid never drops without a handshake, and row_data is stable while row_valid=1 and row_ready=0.
  - A return into one buffer may occur in the same cycle as a handshake on the other buffer.
- Latency and throughput:
  - First row_valid appears N+RD_LAT cycles after the cycle in which start was sampled.
  - With row_ready held high, one row is delivered every N cycles sustained.
- Wrap: addresses k_base+i >= KMAX wrap to 0. k_count=KMAX covers every row exactly once.
- Reset mid-command: immediate return to reset state. Partial rows and buffered rows are discarded, and no done pulse is produced.

Optional Feature:
- Macro XSTREAM_STRIDE_EN.
- Defined: adds input port k_stride (K_W bits), latched at start. Row i address = (k_base + i*k_stride) mod KMAX, computed by accumulation (no multiplier). A stride of 0 repeats row k_base.
- Undefined: the port is absent and the stride is fixed at 1.

Test Plan:
- Preload SRAM model with value B000_0000+(k<<16)+n, RD_LAT=1, row_ready=1. Command k_base=0, k_count=4 -> rows k=0..3 delivered in order with row_data matching the pattern; row_last on k=3; done pulses once; total rd_en count = 32.
- Back-pressure: k_base=7, k_count=3, row_ready=0 for 40 cycles then 1 -> at most 2 rows are buffered, rd_en stalls at the third row's element 0, row_data stays stable while stalled, and rows 7, 8, 9 are delivered intact.
- Wrap: k_base=1022, k_count=4 -> row_k sequence is 1022, 1023, 0, 1.
- Edge commands: k_count=0 -> done pulses 1 cycle after start and there are no rd_en. A start pulsed while busy is ignored, so the first command completes unchanged.
- Latency sweep: RD_LAT=1..4 with k_count=5 and row_ready=1 -> first row_valid at N+RD_LAT cycles, then one row every 8 cycles.
- Reset mid-command: assert rst_n=0 after row 1 is delivered in a k_count=6 run -> all outputs 0 and no done pulse. A new command with k_base=3, k_count=2 then delivers rows 3 and 4 correctly. With XSTREAM_STRIDE_EN defined, k_stride=3, k_base=0, k_count=4 -> rows 0, 3, 6, 9.
